light_pattern_gen: RTL

Generates the three scrolling note-lane light patterns (L1, L2, L3) that the level-dependent light combiner merges onto the LED bar. A divided game tick shifts each lane one position, and a per-lane LFSR injects new notes. Lanes are gated by the current level. New notes are mutually exclusive across lanes, so the combined patterns never overlap. The block sits between the game-control FSM (enable, level, clear) and the light combiner.

---
 rtl/light_pattern_gen_pkg.sv | 22 ++
 rtl/light_pattern_gen_lfsr8.sv | 25 ++
 rtl/light_pattern_gen.sv | 91 +++++++++
 3 files changed

// File: rtl/light_pattern_gen_pkg.sv
// Shared constants for the note-lane light pattern generator.
// Holds the lane width, the LFSR taps, the level encodings and the default lane seeds.
package light_pattern_gen_pkg;

    localparam int WIDTH_DEF = 17;

    // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam logic [1:0] SEL_L1   = 2'b00;
    localparam logic [1:0] SEL_L12  = 2'b01;
    localparam logic [1:0] SEL_L123 = 2'b11;

    localparam logic [7:0] SEED1_DEF = 8'h01;
    localparam logic [7:0] SEED2_DEF = 8'h5A;
    localparam logic [7:0] SEED3_DEF = 8'hC3;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/light_pattern_gen_lfsr8.sv
// 8-bit Fibonacci LFSR for one note lane.
// The register loads its seed on reset and advances only when adv is high.
module lfsr8
    import light_pattern_gen_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seed,
    input  logic       adv,
    output logic [7:0] q
);

    logic [7:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= seed;
        end else if (adv) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/light_pattern_gen.sv
// Scrolling three-lane note pattern generator: a divided tick shifts each lane toward the
// strike end while per-lane LFSRs inject new notes, gated by level and mutually exclusive.
module light_pattern_gen
    import light_pattern_gen_pkg::*;
#(
    parameter int         WIDTH    = WIDTH_DEF,
    parameter int         TICK_DIV = 12_500_000,
    parameter logic [7:0] SEED1    = SEED1_DEF,
    parameter logic [7:0] SEED2    = SEED2_DEF,
    parameter logic [7:0] SEED3    = SEED3_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] L1,
    output logic [WIDTH-1:0] L2,
    output logic [WIDTH-1:0] L3,
    output logic             step,
    output logic [7:0]       step_count
);

    localparam int              DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [WIDTH-1:0] r_l1, r_l2, r_l3;
    logic [DIV_W-1:0] r_div;
    logic             r_step;
    logic [7:0]       r_step_count;

    logic [7:0] w_lfsr1, w_lfsr2, w_lfsr3;
    logic       w_step_edge, w_adv;
    logic       w_lane2_on, w_lane3_on;
    logic       w_n1, w_n2, w_n3;
    logic       w_unused_lfsr_hi;

    // LFSRs keep running across clear so the note sequence is not replayed after a flush.
    lfsr8 u_lfsr1 (.clk(clk), .reset(reset), .seed(SEED1), .adv(w_adv), .q(w_lfsr1));
    lfsr8 u_lfsr2 (.clk(clk), .reset(reset), .seed(SEED2), .adv(w_adv), .q(w_lfsr2));
    lfsr8 u_lfsr3 (.clk(clk), .reset(reset), .seed(SEED3), .adv(w_adv), .q(w_lfsr3));

    assign w_unused_lfsr_hi = ^{w_lfsr1[7:2], w_lfsr2[7:2], w_lfsr3[7:2]};

    always_comb begin
        w_step_edge = enable && (r_div == DIV_LAST);
        w_adv       = w_step_edge && !clear;
        w_lane2_on  = (select == SEL_L12) || (select == SEL_L123);
        w_lane3_on  = (select == SEL_L123);
        // Lower lanes win, and a lane never takes a note right behind its previous one.
        w_n1 = (w_lfsr1[1:0] == 2'b00) && !r_l1[0];
        w_n2 = (w_lfsr2[1:0] == 2'b00) && w_lane2_on && !r_l2[0] && !w_n1;
        w_n3 = (w_lfsr3[1:0] == 2'b00) && w_lane3_on && !r_l3[0] && !w_n1 && !w_n2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_l1         <= '0;
            r_l2         <= '0;
            r_l3         <= '0;
            r_div        <= '0;
            r_step       <= 1'b0;
            r_step_count <= 8'd0;
        end else if (clear) begin
            r_l1   <= '0;
            r_l2   <= '0;
            r_l3   <= '0;
            r_div  <= '0;
            r_step <= 1'b0;
        end else if (w_step_edge) begin
            r_l1         <= {r_l1[WIDTH-2:0], w_n1};
            r_l2         <= {r_l2[WIDTH-2:0], w_n2};
            r_l3         <= {r_l3[WIDTH-2:0], w_n3};
            r_div        <= '0;
            r_step       <= 1'b1;
            r_step_count <= r_step_count + 8'd1;
        end else begin
            r_step <= 1'b0;
            if (enable) begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign L1         = r_l1;
    assign L2         = r_l2;
    assign L3         = r_l3;
    assign step       = r_step;
    assign step_count = r_step_count;

endmodule
